// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type, block alignment and bus agent states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t BLK_ALIGN_MASK = 32'hFFFF_FFF8;

    typedef enum logic [3:0] {
        BA_IDLE     = 4'd0,
        BA_FILL0    = 4'd1,
        BA_FILL1    = 4'd2,
        BA_WB0      = 4'd3,
        BA_WB1      = 4'd4,
        BA_SNP_LOOK = 4'd5,
        BA_SNP_RESP = 4'd6,
        BA_SNP_WB0  = 4'd7,
        BA_SNP_WB1  = 4'd8,
        BA_SNP_WAIT = 4'd9,
        BA_DONE     = 4'd10
    } bus_agent_state_t;

    function automatic word_t blk_align(input word_t addr);
        return addr & BLK_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dcache_bus_agent_if.sv
// rtl/dcache_bus_agent_if.sv - dcache data and coherence channel to the bus arbiter
interface dcache_bus_agent_if;
    import cpu_types_pkg::*;

    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;
    logic  ccwait;
    logic  ccinv;
    word_t ccsnoopaddr;
    logic  cctrans;
    logic  ccwrite;

    modport master (
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr
    );

    modport slave (
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr
    );

endinterface

// File: rtl/snoop_buffer.sv
// rtl/snoop_buffer.sv - captured tag lookup result and block data for one snoop
module snoop_buffer
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  clear,
    input  logic  hit_in,
    input  logic  dirty_in,
    input  word_t data0_in,
    input  word_t data1_in,
    output logic  hit,
    output logic  dirty,
    output word_t data0,
    output word_t data1
);

    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            hit   <= 1'b0;
            dirty <= 1'b0;
            data0 <= '0;
            data1 <= '0;
        end else if (load) begin
            hit   <= hit_in;
            dirty <= dirty_in;
            data0 <= data0_in;
            data1 <= data1_in;
        end
    end

endmodule

// File: rtl/dcache_bus_agent.sv
// rtl/dcache_bus_agent.sv - dcache block fill/writeback engine with snoop responder
module dcache_bus_agent
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  req_fill,
    input  logic  req_wb,
    input  logic  req_excl,
    input  word_t req_addr,
    input  word_t wb_data0,
    input  word_t wb_data1,
    output word_t fill_data0,
    output word_t fill_data1,
    output logic  done,
    output word_t snp_addr,
    input  logic  snp_hit,
    input  logic  snp_dirty,
    input  word_t snp_rdata0,
    input  word_t snp_rdata1,
    output logic  snp_inv,
    output logic  snp_downgrade,
    dcache_bus_agent_if.master bus
);

    localparam logic [3:0] ST_IDLE     = BA_IDLE;
    localparam logic [3:0] ST_FILL0    = BA_FILL0;
    localparam logic [3:0] ST_FILL1    = BA_FILL1;
    localparam logic [3:0] ST_WB0      = BA_WB0;
    localparam logic [3:0] ST_WB1      = BA_WB1;
    localparam logic [3:0] ST_SNP_LOOK = BA_SNP_LOOK;
    localparam logic [3:0] ST_SNP_RESP = BA_SNP_RESP;
    localparam logic [3:0] ST_SNP_WB0  = BA_SNP_WB0;
    localparam logic [3:0] ST_SNP_WB1  = BA_SNP_WB1;
    localparam logic [3:0] ST_SNP_WAIT = BA_SNP_WAIT;
    localparam logic [3:0] ST_DONE     = BA_DONE;

    logic [3:0] state, state_nxt;
    logic       look_phase;
    logic       ret_busy;
    logic       ret_wb;
    logic       buf_hit, buf_dirty;
    word_t      buf_data0, buf_data1;

    snoop_buffer u_snoop_buffer (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (state == ST_SNP_LOOK && look_phase),
        .clear    (state == ST_SNP_WAIT && !bus.ccwait),
        .hit_in   (snp_hit),
        .dirty_in (snp_dirty),
        .data0_in (snp_rdata0),
        .data1_in (snp_rdata1),
        .hit      (buf_hit),
        .dirty    (buf_dirty),
        .data0    (buf_data0),
        .data1    (buf_data1)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.ccwait)    state_nxt = ST_SNP_LOOK;
                else if (req_fill) state_nxt = ST_FILL0;
                else if (req_wb)   state_nxt = ST_WB0;
            end
            ST_FILL0: begin
                if (bus.ccwait)      state_nxt = ST_SNP_LOOK;
                else if (!bus.dwait) state_nxt = ST_FILL1;
            end
            ST_FILL1:    if (!bus.dwait) state_nxt = ST_DONE;
            ST_WB0: begin
                if (bus.ccwait)      state_nxt = ST_SNP_LOOK;
                else if (!bus.dwait) state_nxt = ST_WB1;
            end
            ST_WB1:      if (!bus.dwait) state_nxt = ST_DONE;
            ST_SNP_LOOK: if (look_phase) state_nxt = ST_SNP_RESP;
            ST_SNP_RESP: state_nxt = (buf_hit && buf_dirty) ? ST_SNP_WB0 : ST_SNP_WAIT;
            ST_SNP_WB0:  if (!bus.dwait) state_nxt = ST_SNP_WB1;
            ST_SNP_WB1:  if (!bus.dwait) state_nxt = ST_SNP_WAIT;
            ST_SNP_WAIT: begin
                if (!bus.ccwait)
                    state_nxt = !ret_busy ? ST_IDLE : (ret_wb ? ST_WB0 : ST_FILL0);
            end
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Lookup takes two cycles: publish snp_addr, then capture the tag result.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= ST_IDLE;
            look_phase    <= 1'b0;
            ret_busy      <= 1'b0;
            ret_wb        <= 1'b0;
            snp_addr      <= '0;
            fill_data0    <= '0;
            fill_data1    <= '0;
            snp_downgrade <= 1'b0;
        end else begin
            state         <= state_nxt;
            look_phase    <= (state == ST_SNP_LOOK) && !look_phase;
            snp_downgrade <= (state == ST_SNP_WB1) && !bus.dwait;
            if (state == ST_SNP_LOOK && !look_phase)
                snp_addr <= blk_align(bus.ccsnoopaddr);
            if (state_nxt == ST_SNP_LOOK && state != ST_SNP_LOOK) begin
                ret_busy <= (state != ST_IDLE);
                ret_wb   <= (state == ST_WB0);
            end
            if (state == ST_FILL0 && !bus.ccwait && !bus.dwait)
                fill_data0 <= bus.dload;
            if (state == ST_FILL1 && !bus.dwait)
                fill_data1 <= bus.dload;
        end
    end

    always_comb begin
        bus.dREN    = 1'b0;
        bus.dWEN    = 1'b0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.cctrans = 1'b0;
        bus.ccwrite = 1'b0;
        snp_inv     = 1'b0;
        case (state)
            ST_FILL0, ST_FILL1: begin
                bus.dREN    = 1'b1;
                bus.daddr   = blk_align(req_addr);
                bus.ccwrite = req_excl;
            end
            ST_WB0, ST_WB1: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = blk_align(req_addr);
                bus.dstore = (state == ST_WB0) ? wb_data0 : wb_data1;
            end
            ST_SNP_RESP: begin
                bus.cctrans = 1'b1;
                bus.ccwrite = buf_hit && buf_dirty;
                snp_inv     = bus.ccinv && buf_hit;
            end
            ST_SNP_WB0: bus.dstore = buf_data0;
            ST_SNP_WB1: bus.dstore = buf_data1;
            default: ;
        endcase
    end

    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_dcache_bus_agent.sv
// tb/tb_dcache_bus_agent.sv - self-checking bench for dcache_bus_agent
module tb_dcache_bus_agent;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  req_fill, req_wb, req_excl;
    word_t req_addr, wb_data0, wb_data1;
    word_t fill_data0, fill_data1, snp_addr, snp_rdata0, snp_rdata1;
    logic  done, snp_hit, snp_dirty, snp_inv, snp_downgrade;

    dcache_bus_agent_if bus();

    dcache_bus_agent dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .req_fill      (req_fill),
        .req_wb        (req_wb),
        .req_excl      (req_excl),
        .req_addr      (req_addr),
        .wb_data0      (wb_data0),
        .wb_data1      (wb_data1),
        .fill_data0    (fill_data0),
        .fill_data1    (fill_data1),
        .done          (done),
        .snp_addr      (snp_addr),
        .snp_hit       (snp_hit),
        .snp_dirty     (snp_dirty),
        .snp_rdata0    (snp_rdata0),
        .snp_rdata1    (snp_rdata1),
        .snp_inv       (snp_inv),
        .snp_downgrade (snp_downgrade),
        .bus           (bus.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit    is_wb;
        bit    excl;
        word_t addr;
        word_t d0;
        word_t d1;
        int    stall;
    } vec_t;

    vec_t  vecs[6];
    word_t exp_q[$];
    int    tests  = 0;
    int    failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dREN"}, bus.dREN, 0);
        check({tag, "_dWEN"}, bus.dWEN, 0);
        check({tag, "_daddr"}, bus.daddr, 0);
        check({tag, "_dstore"}, bus.dstore, 0);
        check({tag, "_cctrans"}, bus.cctrans, 0);
        check({tag, "_ccwrite"}, bus.ccwrite, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fill_data0"}, fill_data0, 0);
        check({tag, "_fill_data1"}, fill_data1, 0);
        check({tag, "_snp_addr"}, snp_addr, 0);
        check({tag, "_snp_inv"}, snp_inv, 0);
        check({tag, "_snp_downgrade"}, snp_downgrade, 0);
    endtask

    // Drives one fill/writeback; done must appear 1 + 2*(stall+1) edges after start.
    task automatic run_req(input vec_t v);
        int cyc   = 0;
        int stall = 0;
        int beat  = 0;
        bit got   = 0;
        exp_q.delete();
        req_fill = !v.is_wb; req_wb = v.is_wb; req_excl = v.excl;
        req_addr = v.addr;   wb_data0 = v.d0;  wb_data1 = v.d1;
        exp_q.push_back(v.d0);
        exp_q.push_back(v.d1);
        bus.dwait = 1'b1;
        while (!got && cyc < 60) begin
            @(posedge CLK); #1; cyc++;
            if (done) begin
                got = 1; req_fill = 0; req_wb = 0; bus.dwait = 1'b1;
                check("done_latency", cyc, 1 + 2 * (v.stall + 1));
                check("beats", beat, 2);
                if (!v.is_wb) begin
                    check("fill_data0", fill_data0, exp_q.pop_front());
                    check("fill_data1", fill_data1, exp_q.pop_front());
                end
            end else if (bus.dREN || bus.dWEN) begin
                check("req_kind", bus.dWEN, v.is_wb);
                check("daddr", bus.daddr, v.addr & 32'hFFFF_FFF8);
                check("ccwrite_req", bus.ccwrite, v.is_wb ? 1'b0 : v.excl);
                if (v.is_wb) check("dstore", bus.dstore, exp_q[0]);
                if (stall < v.stall) begin
                    bus.dwait = 1'b1; stall++;
                end else begin
                    bus.dwait = 1'b0; stall = 0;
                    if (v.is_wb) void'(exp_q.pop_front());
                    else bus.dload = (beat == 0) ? v.d0 : v.d1;
                    beat++;
                end
            end else begin
                bus.dwait = 1'b1;
            end
        end
        if (!got) check("done_timeout", 0, 1);
        @(posedge CLK); #1;
        check("done_width", done, 0);
    endtask

    // Raises ccwait for one snoop, acts as arbiter for the response and writeback.
    task automatic run_snoop(input word_t addr, input bit hit, input bit dirty,
                             input word_t d0, input word_t d1, input bit inv);
        int cyc = 0, trans_cyc = 0, trans_cnt = 0, inv_cnt = 0;
        int dg_cnt = 0, dg_cyc = 0, beats = 0, stray = 0, tail = -1;
        bit wb = hit & dirty;
        exp_q.delete();
        snp_hit = hit; snp_dirty = dirty; snp_rdata0 = d0; snp_rdata1 = d1;
        bus.ccsnoopaddr = addr; bus.ccinv = inv; bus.ccwait = 1'b1; bus.dwait = 1'b1;
        while (tail != 0 && cyc < 40) begin
            @(posedge CLK); #1; cyc++;
            if (tail > 0) tail--;
            if (bus.cctrans) begin
                trans_cnt++;
                if (trans_cyc == 0) begin
                    trans_cyc = cyc;
                    check("ccwrite_snp", bus.ccwrite, wb);
                    if (wb) begin exp_q.push_back(d0); exp_q.push_back(d1); end
                end
            end
            if (snp_inv) inv_cnt++;
            if (snp_downgrade) begin dg_cnt++; dg_cyc = cyc; end
            if (bus.ccwait && (bus.dREN || bus.dWEN)) stray++;
            if (wb && trans_cyc != 0 && cyc > trans_cyc && beats < 2) begin
                check("snp_dstore", bus.dstore, exp_q.pop_front());
                bus.dwait = 1'b0; beats++;
            end else begin
                bus.dwait = 1'b1;
                if (bus.ccwait && bus.dstore != 0) stray++;
            end
            if (bus.ccwait && trans_cyc != 0 && (!wb || dg_cnt > 0)) begin
                bus.ccwait = 1'b0; tail = 2;
            end
        end
        check("cctrans_time", trans_cyc, 3);
        check("cctrans_width", trans_cnt, 1);
        check("snp_addr", snp_addr, addr & 32'hFFFF_FFF8);
        check("snp_inv_cnt", inv_cnt, inv & hit);
        check("snp_downgrade_cnt", dg_cnt, wb);
        check("snp_downgrade_time", dg_cyc, wb ? trans_cyc + 3 : 0);
        check("snp_beats", beats, wb ? 2 : 0);
        check("snp_stray", stray, 0);
        bus.ccinv = 0; bus.ccwait = 0; snp_hit = 0; snp_dirty = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{is_wb: 0, excl: 0, addr: 32'h0000_1004, d0: 32'hAAAA_0000, d1: 32'hBBBB_0001, stall: 1};
        vecs[1] = '{is_wb: 1, excl: 0, addr: 32'h0000_2008, d0: 32'h0000_0011, d1: 32'h0000_0022, stall: 0};
        vecs[2] = '{is_wb: 0, excl: 1, addr: 32'h0000_FFFF, d0: 32'h1357_9BDF, d1: 32'h2468_ACE0, stall: 0};
        vecs[3] = '{is_wb: 1, excl: 0, addr: 32'hFFFF_FFFC, d0: 32'hCAFE_F00D, d1: 32'h0BAD_BEEF, stall: 3};
        vecs[4] = '{is_wb: 0, excl: 0, addr: 32'h8000_0007, d0: 32'h0F0F_0F0F, d1: 32'hF0F0_F0F0, stall: 2};
        vecs[5] = '{is_wb: 1, excl: 1, addr: 32'h1234_5670, d0: 32'h5A5A_5A5A, d1: 32'hA5A5_A5A5, stall: 1};

        nRST = 0; req_fill = 0; req_wb = 0; req_excl = 0;
        req_addr = 0; wb_data0 = 0; wb_data1 = 0;
        snp_hit = 0; snp_dirty = 0; snp_rdata0 = 0; snp_rdata1 = 0;
        bus.dwait = 1; bus.dload = 0; bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle("reset");
        nRST = 1;

        for (int i = 0; i < 6; i++) run_req(vecs[i]);

        run_snoop(32'h0000_3004, 1, 0, 32'h5555_0000, 32'h6666_0000, 1);
        run_snoop(32'h0000_3010, 1, 1, 32'h0000_DEAD, 32'h0000_BEEF, 0);
        run_snoop(32'h0000_5000, 0, 0, 32'h7777_0000, 32'h8888_0000, 1);

        // Fill preempted in FILL0 by a dirty snoop, then resumed.
        req_fill = 1; req_excl = 1; req_addr = 32'h0000_4000; bus.dwait = 1;
        @(posedge CLK); #1;
        check("preempt_fill_ren", bus.dREN, 1);
        run_snoop(32'h0000_6008, 1, 1, 32'h0000_1234, 32'h0000_5678, 0);
        check("resume_fill_ren", bus.dREN, 1);
        check("resume_fill_daddr", bus.daddr, 32'h0000_4000);
        run_req('{is_wb: 0, excl: 1, addr: 32'h0000_4000, d0: 32'h9999_0000, d1: 32'h7777_0001, stall: 0});

        // Writeback preempted in WB0 by a clean snoop, then resumed.
        req_wb = 1; req_addr = 32'h0000_7008; wb_data0 = 32'h0000_00A1; wb_data1 = 32'h0000_00B2;
        @(posedge CLK); #1;
        check("preempt_wb_wen", bus.dWEN, 1);
        run_snoop(32'h0000_9000, 1, 0, 32'h0000_0001, 32'h0000_0002, 0);
        check("resume_wb_wen", bus.dWEN, 1);
        run_req('{is_wb: 1, excl: 0, addr: 32'h0000_7008, d0: 32'h0000_00A1, d1: 32'h0000_00B2, stall: 1});

        // Reset asserted in FILL1 aborts with no done pulse.
        req_fill = 1; req_excl = 0; req_addr = 32'h0000_8000; bus.dwait = 1;
        @(posedge CLK); #1;
        bus.dload = 32'hCAFE_0000; bus.dwait = 0;
        @(posedge CLK); #1;
        check("fill1_latched", fill_data0, 32'hCAFE_0000);
        nRST = 0; bus.dwait = 1;
        @(posedge CLK); #1;
        check_idle("midreset");
        nRST = 1; req_fill = 0;
        begin
            int done_seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge CLK); #1;
                if (done || bus.dREN) done_seen++;
            end
            check("midreset_no_done", done_seen, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dcache_bus_agent.md
# dcache_bus_agent

Cache-side endpoint of the coherent memory bus. One instance sits between each core's dcache controller and its slice of the bus arbiter's cache/coherence channel. The block does two jobs. It runs the dcache's own two-word block fills (BusRd/BusRdX) and block writebacks, and it answers the arbiter's snoops: it reports hit and dirty status, supplies dirty blocks, and drives invalidate/downgrade commands into the tag array.

## Interface
- No parameters. The word type is `word_t` and the block is 2 words, 8 bytes (`cpu_types_pkg`).
- `CLK` in 1: clock. All state changes on the rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `req_fill` in 1: dcache requests a block fill. Level signal, held until `done`.
- `req_wb` in 1: dcache requests a block writeback. Level signal. Mutually exclusive with `req_fill`.
- `req_excl` in 1: the fill is for a store (BusRdX).
- `req_addr` in 32: block address. Bits [2:0] are ignored.
- `wb_data0`, `wb_data1` in 32 each: victim block words, stable while `req_wb` is held.
- `fill_data0`, `fill_data1` out 32 each: registered fill words, valid from `done` until the next fill starts.
- `done` out 1: one-cycle pulse when the request completes.
- `snp_addr` out 32: block-aligned snoop lookup address sent to the tag array.
- `snp_hit`, `snp_dirty` in 1 each: combinational tag lookup result for `snp_addr`.
- `snp_rdata0`, `snp_rdata1` in 32 each: block data for `snp_addr`.
- `snp_inv` out 1: one-cycle pulse; invalidate the line at `snp_addr`.
- `snp_downgrade` out 1: one-cycle pulse; move the line at `snp_addr` from M to S.
- Bus side: `dREN`, `dWEN` out 1; `daddr`, `dstore` out 32; `dwait` in 1; `dload` in 32; `ccwait`, `ccinv` in 1; `ccsnoopaddr` in 32; `cctrans`, `ccwrite` out 1.

## Operation
- States: IDLE, FILL0, FILL1, WB0, WB1, SNP_LOOK, SNP_RESP, SNP_WB0, SNP_WB1, SNP_WAIT, DONE.
- IDLE transitions:
  - `ccwait` → SNP_LOOK.
  - Otherwise `req_fill` → FILL0.
  - Otherwise `req_wb` → WB0.
- Fill:
  - FILL0 drives `dREN`=1, `daddr`={req_addr[31:3],000}, `ccwrite`=`req_excl`.
  - First `dwait`=0: latch `dload` into `fill_data0`, go to FILL1.
  - FILL1 keeps the same outputs. Next `dwait`=0: latch `fill_data1`, go to DONE.
- Writeback:
  - WB0 drives `dWEN`=1, `daddr` aligned, `dstore`=`wb_data0`. `dwait`=0 → WB1.
  - WB1 drives `dstore`=`wb_data1`. `dwait`=0 → DONE.
- DONE: pulse `done`, all bus outputs 0, `req_*` ignored, then IDLE. The requester drops its `req_*` in the DONE cycle.
- Snoop preemption:
  - `ccwait`=1 while in FILL0 or WB0 before the first `dwait`=0 forces SNP_LOOK.
  - The current state is saved in a 1-bit return register plus the kind of request.
  - Bus request outputs deassert during the snoop. The request restarts at FILL0 or WB0 afterwards.
  - `ccwait` cannot rise in FILL1 or WB1. If it does, it is ignored.
- Snoop lookup:
  - SNP_LOOK registers `snp_addr`={ccsnoopaddr[31:3],000}. Next cycle it samples `snp_hit`, `snp_dirty` and `snp_rdata*` into a snoop buffer, then goes to SNP_RESP.
- SNP_RESP:
  - Drives `cctrans`=1 and `ccwrite`=(hit&dirty).
  - If `ccinv`=1 this cycle and hit: pulse `snp_inv`.
  - If dirty → SNP_WB0. Otherwise → SNP_WAIT.
- Snoop writeback:
  - SNP_WB0 drives `dstore`=buf0. `dwait`=0 → SNP_WB1.
  - SNP_WB1 drives `dstore`=buf1. `dwait`=0: pulse `snp_downgrade`, go to SNP_WAIT.
- SNP_WAIT: hold outputs at 0 until `ccwait`=0, then return (IDLE or the saved request state).
- Snoop miss: `cctrans`=1, `ccwrite`=0, no tag command.

## Timing
- Reset: state IDLE. Every output is 0, including `fill_data*` and the snoop buffer.
- Reset asserted mid-transfer aborts the transfer. No `done` pulse.
- Snoop response: `cctrans` rises exactly 2 cycles after the first `ccwait`=1 sample and stays high for 1 cycle.
- Fill latency: 1 cycle of request setup, then the arbiter's `dwait` cadence, plus 1 cycle for DONE. `done` follows the second `dwait`=0 by 1 cycle.
- Outputs are registered state decode. `dstore` and `daddr` are muxes of registered or stable inputs. There is no combinational path from `dwait` to any output.
- Simultaneous `ccwait` and `req_*` in IDLE: the snoop wins.

## Structure
- Add `bus_agent_state_t` (enum) and `BLK_ALIGN_MASK` to `cpu_types_pkg`. Keep `word_t` in the same package.
- Natural sub-module: `snoop_buffer`. It holds the two-word, hit and dirty registers with load and clear.
- The top-level dcache wires the bus ports to its `cache_control_if` slice.

## Test plan
- Fill of 0x0000_1004 with `req_excl`=0, `dwait` low on cycles 3 and 5 with `dload`=0xAAAA_0000 then 0xBBBB_0001:
  - `daddr`=0x1000, `ccwrite`=0.
  - `fill_data0/1` equal those words.
  - `done` pulses on cycle 6.
- Writeback of {0x11, 0x22} to 0x2008:
  - `dstore`=0x11 until the first `dwait`=0, then 0x22.
  - `done` pulses 1 cycle after the second `dwait`=0.
- Snoop of 0x3000 hitting a clean line with `ccinv`=1 in SNP_RESP:
  - `cctrans`=1, `ccwrite`=0, `snp_inv` pulses.
  - No `dstore` activity.
- Snoop hitting dirty {0xDEAD, 0xBEEF}:
  - `ccwrite`=1.
  - `dstore` sequence 0xDEAD then 0xBEEF.
  - `snp_downgrade` pulses after the second `dwait`=0.
- `req_fill` pending in FILL0 when `ccwait` rises:
  - `dREN` drops.
  - The snoop completes.
  - `dREN` reasserts after `ccwait` falls.
  - The fill completes normally.
- `nRST`=0 during FILL1: next cycle all outputs are 0, state is IDLE, and there is no `done`.
